// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch front end.
// Issues word reads, tracks them across a fixed memory latency and
// buffers the returned words with their PCs in a small FIFO for decode.
//
// Handshake: out_valid says the FIFO head (out_instr/out_pc) is real.
// A transfer happens on a rising edge where out_valid && out_ready are
// both high and flush is low. The head never changes except by that
// transfer, a flush or reset. out_ready may depend on out_valid, but
// out_valid never depends on out_ready.
module fetch_queue #(
  parameter int unsigned       WIDTH    = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       MEM_LAT  = 1,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           flush_tgt,
  input  logic                       halt,
  output logic                       mem_read_en,
  output logic [WIDTH-1:0]           mem_read_addr,
  input  logic [WIDTH-1:0]           mem_read_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_instr,
  output logic [WIDTH-1:0]           out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  // Wide enough for occupancy plus up to three reads in flight.
  localparam int CNT_W = OCC_W + 2;

  logic [WIDTH-1:0] fetch_pc_q;
  logic [MEM_LAT-1:0] slot_v_q;
  logic [WIDTH-1:0] slot_pc_q [MEM_LAT];
  logic [WIDTH-1:0] fifo_instr_q [DEPTH];
  logic [WIDTH-1:0] fifo_pc_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [OCC_W-1:0] count_q;

  logic [CNT_W-1:0] inflight;
  logic             credit_ok;
  logic             issue;
  logic             push;
  logic             pop;

  // Count reads still travelling through the memory pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + CNT_W'(slot_v_q[i]);
    end
  end

  // A read is only issued when a FIFO entry is guaranteed for its data,
  // so a returning word can never find the FIFO full.
  assign credit_ok = ({2'b00, count_q} + inflight) < CNT_W'(DEPTH);
  assign issue     = rst_n & ~halt & ~flush & credit_ok;
  assign push      = slot_v_q[MEM_LAT-1] & ~flush;
  assign pop       = (count_q != '0) & out_ready & ~flush;

  assign mem_read_en   = issue;
  assign mem_read_addr = fetch_pc_q;
  assign out_valid     = (count_q != '0);
  assign out_instr     = fifo_instr_q[rd_ptr_q];
  assign out_pc        = fifo_pc_q[rd_ptr_q];
  assign occupancy     = count_q;

  // Control state: fetch PC, in-flight valid bits, FIFO pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      slot_v_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (flush) begin
      // Squash everything, including a response arriving this cycle.
      fetch_pc_q <= flush_tgt;
      slot_v_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (issue) begin
        fetch_pc_q <= fetch_pc_q + WIDTH'(1);
      end
      slot_v_q[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) begin
        slot_v_q[i] <= slot_v_q[i-1];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Datapath: PCs riding alongside the reads, and FIFO storage.
  always_ff @(posedge clk) begin
    slot_pc_q[0] <= fetch_pc_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      slot_pc_q[i] <= slot_pc_q[i-1];
    end
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= mem_read_data;
      fifo_pc_q[wr_ptr_q]    <= slot_pc_q[MEM_LAT-1];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed per-cycle vector tables against two instances,
// one with a 1-cycle and one with a 3-cycle instruction memory.
// Memory models return data = address + 0x100.
module tb_fetch_queue;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         halt = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] flush_tgt = '0;

  // ---------------- DUT with MEM_LAT=1 ----------------
  logic         m1_en, o1_valid;
  logic [W-1:0] m1_addr, m1_data, o1_instr, o1_pc;
  logic [2:0]   o1_occ;
  logic [W-1:0] m1_q;

  fetch_queue #(.WIDTH(W), .DEPTH(4), .MEM_LAT(1), .RESET_PC(16'h0000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_tgt(flush_tgt), .halt(halt),
    .mem_read_en(m1_en), .mem_read_addr(m1_addr), .mem_read_data(m1_data),
    .out_valid(o1_valid), .out_instr(o1_instr), .out_pc(o1_pc),
    .out_ready(out_ready), .occupancy(o1_occ)
  );

  always @(posedge clk) m1_q <= m1_addr + 16'h0100;
  assign m1_data = m1_q;

  // ---------------- DUT with MEM_LAT=3 ----------------
  logic         m3_en, o3_valid;
  logic [W-1:0] m3_addr, m3_data, o3_instr, o3_pc;
  logic [2:0]   o3_occ;
  logic [W-1:0] m3_q [3];

  fetch_queue #(.WIDTH(W), .DEPTH(4), .MEM_LAT(3), .RESET_PC(16'h0000)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_tgt(flush_tgt), .halt(halt),
    .mem_read_en(m3_en), .mem_read_addr(m3_addr), .mem_read_data(m3_data),
    .out_valid(o3_valid), .out_instr(o3_instr), .out_pc(o3_pc),
    .out_ready(out_ready), .occupancy(o3_occ)
  );

  always @(posedge clk) begin
    m3_q[0] <= m3_addr + 16'h0100;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign m3_data = m3_q[2];

  // ---------------- vector table ----------------
  typedef struct {
    logic         flush;
    logic [W-1:0] tgt;
    logic         halt;
    logic         ready;
    logic         exp_en;
    logic [W-1:0] exp_addr;   // checked only when exp_en
    logic         chk_out;    // 0 in flush cycles: head is don't-care
    logic         exp_valid;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_instr;
    logic [2:0]   exp_occ;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic fl, input logic [W-1:0] tg, input logic hl,
                     input logic rd, input logic en, input logic [W-1:0] ad,
                     input logic ck, input logic vl, input logic [W-1:0] pc,
                     input logic [2:0] oc);
    vec_t v;
    v.flush = fl; v.tgt = tg; v.halt = hl; v.ready = rd;
    v.exp_en = en; v.exp_addr = ad; v.chk_out = ck; v.exp_valid = vl;
    v.exp_pc = pc; v.exp_instr = pc + 16'h0100; v.exp_occ = oc;
    tbl.push_back(v);
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check_vec(input int which, input vec_t v, input string tag, input int idx);
    logic         en, vl;
    logic [W-1:0] ad, pc, ins;
    logic [2:0]   oc;
    logic         bad;
    if (which == 1) begin
      en = m1_en; ad = m1_addr; vl = o1_valid; pc = o1_pc; ins = o1_instr; oc = o1_occ;
    end else begin
      en = m3_en; ad = m3_addr; vl = o3_valid; pc = o3_pc; ins = o3_instr; oc = o3_occ;
    end
    n_vec++;
    bad = (en !== v.exp_en) || (v.exp_en && (ad !== v.exp_addr)) || (oc !== v.exp_occ) ||
          (v.chk_out && (vl !== v.exp_valid)) ||
          (v.chk_out && v.exp_valid && ((pc !== v.exp_pc) || (ins !== v.exp_instr)));
    if (bad) begin
      n_bad++;
      $display("FAIL %s[%0d] dut%0d: got en=%b addr=%h valid=%b pc=%h instr=%h occ=%0d; want en=%b addr=%h valid=%b pc=%h instr=%h occ=%0d",
               tag, idx, which, en, ad, vl, pc, ins, oc,
               v.exp_en, v.exp_addr, v.exp_valid, v.exp_pc, v.exp_instr, v.exp_occ);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle's inputs just after a rising edge, check, advance.
  task automatic run_vec(input int which, input vec_t v, input string tag, input int idx);
    flush = v.flush; flush_tgt = v.tgt; halt = v.halt; out_ready = v.ready;
    #1;
    check_vec(which, v, tag, idx);
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl(input int which, input string tag);
    for (int i = 0; i < tbl.size(); i++) run_vec(which, tbl[i], tag, i);
    tbl.delete();
  endtask

  // Asynchronous reset mid-cycle; both instances must clear immediately.
  // Returns #1 after a rising edge with reset released: that is cycle 0.
  task automatic do_reset(input string tag);
    vec_t r;
    flush = 1'b0; halt = 1'b0; out_ready = 1'b0; flush_tgt = '0;
    rst_n = 1'b0;
    #1;
    r.flush = 0; r.tgt = '0; r.halt = 0; r.ready = 0; r.exp_en = 0; r.exp_addr = '0;
    r.chk_out = 1; r.exp_valid = 0; r.exp_pc = '0; r.exp_instr = '0; r.exp_occ = 3'd0;
    check_vec(1, r, tag, 0);
    check_vec(3, r, tag, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #2;
    do_reset("reset0");

    // Stream from reset, flush while a response arrives (to 0xFFFE, wrap),
    // then back-to-back flushes where the second target wins.
    //  fl  tgt       hl rd  en addr     ck vl pc       occ
    add(0, 16'h0000, 0, 1,  1, 16'h0000, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0001, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0002, 1, 1, 16'h0000, 1);
    add(0, 16'h0000, 0, 1,  1, 16'h0003, 1, 1, 16'h0001, 1);
    add(0, 16'h0000, 0, 1,  1, 16'h0004, 1, 1, 16'h0002, 1);
    add(1, 16'hFFFE, 0, 1,  0, 16'h0000, 0, 0, 16'h0000, 1);
    add(0, 16'h0000, 0, 1,  1, 16'hFFFE, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'hFFFF, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0000, 1, 1, 16'hFFFE, 1);
    add(0, 16'h0000, 0, 1,  1, 16'h0001, 1, 1, 16'hFFFF, 1);
    add(0, 16'h0000, 0, 1,  1, 16'h0002, 1, 1, 16'h0000, 1);
    add(1, 16'h0010, 0, 1,  0, 16'h0000, 0, 0, 16'h0000, 1);
    add(1, 16'h0030, 0, 1,  0, 16'h0000, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0030, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0031, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0032, 1, 1, 16'h0030, 1);
    add(0, 16'h0000, 0, 1,  1, 16'h0033, 1, 1, 16'h0031, 1);
    run_tbl(1, "stream_flush");

    // Backpressure: FIFO fills to 4, issue stops, then drains in order.
    do_reset("reset1");
    add(0, 16'h0000, 0, 0,  1, 16'h0000, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 0,  1, 16'h0001, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 0,  1, 16'h0002, 1, 1, 16'h0000, 1);
    add(0, 16'h0000, 0, 0,  1, 16'h0003, 1, 1, 16'h0000, 2);
    add(0, 16'h0000, 0, 0,  0, 16'h0000, 1, 1, 16'h0000, 3);
    for (int i = 0; i < 5; i++)
      add(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 4);
    add(0, 16'h0000, 0, 1,  0, 16'h0000, 1, 1, 16'h0000, 4);
    add(0, 16'h0000, 0, 1,  1, 16'h0004, 1, 1, 16'h0001, 3);
    add(0, 16'h0000, 0, 1,  1, 16'h0005, 1, 1, 16'h0002, 2);
    add(0, 16'h0000, 0, 1,  1, 16'h0006, 1, 1, 16'h0003, 2);
    add(0, 16'h0000, 0, 1,  1, 16'h0007, 1, 1, 16'h0004, 2);
    add(0, 16'h0000, 0, 1,  1, 16'h0008, 1, 1, 16'h0005, 2);
    run_tbl(1, "backpressure");

    // Halt with two reads in flight (MEM_LAT=3): both land, nothing new issues.
    do_reset("reset2");
    add(0, 16'h0000, 0, 0,  1, 16'h0000, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 0,  1, 16'h0001, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 1, 0,  0, 16'h0000, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 1, 0,  0, 16'h0000, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 1, 0,  0, 16'h0000, 1, 1, 16'h0000, 1);
    for (int i = 0; i < 3; i++)
      add(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 2);
    add(0, 16'h0000, 0, 0,  1, 16'h0002, 1, 1, 16'h0000, 2);
    add(0, 16'h0000, 0, 0,  1, 16'h0003, 1, 1, 16'h0000, 2);
    add(0, 16'h0000, 0, 0,  0, 16'h0000, 1, 1, 16'h0000, 2);
    run_tbl(3, "halt");

    // Flush at cycle 5 with reads in flight (MEM_LAT=3): no stale PCs.
    do_reset("reset3");
    add(0, 16'h0000, 0, 1,  1, 16'h0000, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0001, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0002, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0003, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  0, 16'h0000, 1, 1, 16'h0000, 1);
    add(1, 16'h0040, 0, 1,  0, 16'h0000, 0, 0, 16'h0000, 1);
    add(0, 16'h0000, 0, 1,  1, 16'h0040, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0041, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0042, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0043, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  0, 16'h0000, 1, 1, 16'h0040, 1);
    add(0, 16'h0000, 0, 1,  1, 16'h0044, 1, 1, 16'h0041, 1);
    add(0, 16'h0000, 0, 1,  1, 16'h0045, 1, 1, 16'h0042, 1);
    run_tbl(3, "flush_inflight");

    // Reset pulse mid-stream (both instances streaming): restart at RESET_PC.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    do_reset("reset_mid");
    add(0, 16'h0000, 0, 1,  1, 16'h0000, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0001, 1, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 1,  1, 16'h0002, 1, 1, 16'h0000, 1);
    add(0, 16'h0000, 0, 1,  1, 16'h0003, 1, 1, 16'h0001, 1);
    run_tbl(1, "after_reset");

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
